// File: rtl/clock_division_scheduler_pkg.sv
// Shared types and helpers for the clock division scheduler.
package clock_division_scheduler_pkg;

  // Handshake states: IDLE accepts a request, APPLY is the single busy cycle
  // in which the accepted request is written into the counters.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  // Width of a channel index, never narrower than one bit.
  function automatic int chBits(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_channel_counter.sv
// One tick channel: holds its period (top), counts base ticks and emits a
// one-cycle tick each time the count wraps. A top of zero disables it.
module tick_channel_counter #(
  parameter int BITS = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_base_tick,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic [BITS-1:0] i_top,
  output logic            o_tick
);

  logic [BITS-1:0] top_q, top_d;
  logic [BITS-1:0] count_q, count_d;
  logic            tick_q, tick_d;

  // Next-state: a clear wins over counting so a base tick landing on a
  // reconfiguration never advances the freshly restarted count.
  always_comb begin
    top_d   = i_load ? i_top : top_q;
    count_d = count_q;
    tick_d  = 1'b0;
    if (i_clear || (top_q == '0)) begin
      count_d = BITS'(1);
    end else if (i_base_tick) begin
      if (count_q == top_q) begin
        count_d = BITS'(1);
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + BITS'(1);
      end
    end
  end

  // State registers with synchronous reset to a disabled channel.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      top_q   <= '0;
      count_q <= BITS'(1);
      tick_q  <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/clock_division_scheduler.sv
// Multi-channel tick scheduler: one shared prescaler produces base ticks,
// each channel divides the base tick by its own top value.
module clock_division_scheduler
  import clock_division_scheduler_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  BITS     = 16,
  localparam int CH_BITS  = chBits(CHANNELS)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_prescale_valid,
  input  logic [BITS-1:0]     i_prescale,
  input  logic                i_cfg_valid,
  input  logic [CH_BITS-1:0]  i_cfg_channel,
  input  logic [BITS-1:0]     i_cfg_top,
  output logic                o_cfg_ready,
  output logic [CHANNELS-1:0] o_tick,
  output logic                o_base_tick
);

  state_e               state_q;
  logic                 ready_q;
  logic                 pendPrescale_q;
  logic [CH_BITS-1:0]   pendChannel_q;
  logic [BITS-1:0]      pendValue_q;

  logic [BITS-1:0]      prescale_q, prescale_d;
  logic [BITS-1:0]      base_q, base_d;
  logic                 baseTick_q, baseTick_d;

  logic                 accept;
  logic                 acceptPrescale;
  logic                 acceptCfg;
  logic                 applyPrescale;
  logic                 applyCfg;
  logic [CHANNELS-1:0]  clearVec;
  logic [CHANNELS-1:0]  loadVec;

  assign accept         = (state_q == ST_IDLE) && ready_q && (i_prescale_valid || i_cfg_valid);
  assign acceptPrescale = accept && i_prescale_valid;
  assign acceptCfg      = accept && !i_prescale_valid && i_cfg_valid;
  assign applyPrescale  = (state_q == ST_APPLY) && pendPrescale_q;
  assign applyCfg       = (state_q == ST_APPLY) && !pendPrescale_q;

  // Handshake FSM: latch the winning request on acceptance, spend one busy
  // cycle applying it, then reopen. Prescale beats cfg when both are valid.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      ready_q        <= 1'b0;
      pendPrescale_q <= 1'b0;
      pendChannel_q  <= '0;
      pendValue_q    <= '0;
    end else if (state_q == ST_IDLE) begin
      ready_q <= 1'b1;
      if (accept) begin
        state_q        <= ST_APPLY;
        ready_q        <= 1'b0;
        pendPrescale_q <= i_prescale_valid;
        pendChannel_q  <= i_cfg_channel;
        pendValue_q    <= i_prescale_valid ? i_prescale : i_cfg_top;
      end
    end else begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
    end
  end

  // Shared base counter next-state: wraps at P and flags a base tick,
  // stays frozen while P is zero, restarts when a new P is applied.
  always_comb begin
    prescale_d = prescale_q;
    base_d     = base_q;
    baseTick_d = 1'b0;
    if (applyPrescale) begin
      prescale_d = pendValue_q;
      base_d     = BITS'(1);
    end else if (prescale_q != '0) begin
      if (base_q == prescale_q) begin
        base_d     = BITS'(1);
        baseTick_d = 1'b1;
      end else begin
        base_d = base_q + BITS'(1);
      end
    end
  end

  // Shared base counter registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prescale_q <= '0;
      base_q     <= BITS'(1);
      baseTick_q <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      base_q     <= base_d;
      baseTick_q <= baseTick_d;
    end
  end

  // Per-channel control: targets are cleared both on the accepting edge
  // (so their tick is silent during the busy cycle) and on the apply edge.
  // Out-of-range channel indices match no channel and change nothing.
  always_comb begin
    clearVec = '0;
    loadVec  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (acceptPrescale || applyPrescale) begin
        clearVec[k] = 1'b1;
      end
      if (acceptCfg && (int'(i_cfg_channel) == k)) begin
        clearVec[k] = 1'b1;
      end
      if (applyCfg && (int'(pendChannel_q) == k)) begin
        clearVec[k] = 1'b1;
        loadVec[k]  = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : gChannel
    tick_channel_counter #(
      .BITS(BITS)
    ) uChannel (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_base_tick (baseTick_q),
      .i_clear     (clearVec[k]),
      .i_load      (loadVec[k]),
      .i_top       (pendValue_q),
      .o_tick      (o_tick[k])
    );
  end

  assign o_cfg_ready = ready_q;
  assign o_base_tick = baseTick_q;

endmodule
